// File: rtl/alu_writeback.sv
// ALU result writeback stage: 2-entry in-order register-file queue, CPSR flag
// register, sticky exception accumulator and retired-result counter.
module alu_writeback #(
    parameter int WIDTH     = 16,
    parameter int REGS_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [6:0]           in_flags,
    input  logic [REGS_LOG2-1:0] in_dest,
    input  logic                 in_wr_en,
    input  logic                 in_set_flags,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [WIDTH-1:0]     wb_data,
    output logic [REGS_LOG2-1:0] wb_dest,
    output logic [6:0]           cpsr,
    output logic [2:0]           sticky,
    input  logic                 clr_sticky,
    output logic [15:0]          retired
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } q_state_t;

    q_state_t               state_r;
    q_state_t               state_s;
    logic [WIDTH-1:0]       data0_r;
    logic [WIDTH-1:0]       data0_s;
    logic [WIDTH-1:0]       data1_r;
    logic [WIDTH-1:0]       data1_s;
    logic [REGS_LOG2-1:0]   dest0_r;
    logic [REGS_LOG2-1:0]   dest0_s;
    logic [REGS_LOG2-1:0]   dest1_r;
    logic [REGS_LOG2-1:0]   dest1_s;
    logic                   valid_r;
    logic                   valid_s;
    logic [6:0]             cpsr_r;
    logic [6:0]             cpsr_s;
    logic [2:0]             sticky_r;
    logic [2:0]             sticky_s;
    logic [15:0]            retired_r;
    logic [15:0]            retired_s;
    logic                   accept_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   ready_s;

    // Exception bits {overflow, inf, nan} picked out of the flag vector.
    function automatic logic [2:0] exc_bits(input logic [6:0] flags);
        return {flags[6], flags[2], flags[0]};
    endfunction

    // Handshake decode; non-writing results bypass the queue so never stall.
    always_comb begin
        pop_s    = valid_r & wb_ready;
        ready_s  = (state_r != FULL) | pop_s;
        accept_s = in_valid & (ready_s | ~in_wr_en);
        push_s   = accept_s & in_wr_en;
    end

    // Queue next-state and entry movement; head always lives in slot 0.
    always_comb begin
        state_s = state_r;
        data0_s = data0_r;
        dest0_s = dest0_r;
        data1_s = data1_r;
        dest1_s = dest1_r;
        case (state_r)
            EMPTY: begin
                if (push_s) begin
                    state_s = ONE;
                    data0_s = in_r;
                    dest0_s = in_dest;
                end else begin
                    state_s = EMPTY;
                end
            end
            ONE: begin
                if (push_s && pop_s) begin
                    data0_s = in_r;
                    dest0_s = in_dest;
                end else if (push_s) begin
                    state_s = FULL;
                    data1_s = in_r;
                    dest1_s = in_dest;
                end else if (pop_s) begin
                    state_s = EMPTY;
                end else begin
                    state_s = ONE;
                end
            end
            FULL: begin
                if (pop_s) begin
                    data0_s = data1_r;
                    dest0_s = dest1_r;
                    if (push_s) begin
                        data1_s = in_r;
                        dest1_s = in_dest;
                    end else begin
                        state_s = ONE;
                    end
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = EMPTY;
            end
        endcase
        valid_s = (state_s != EMPTY);
    end

    // Flag register, sticky accumulator (set beats clear) and retire counter.
    always_comb begin
        cpsr_s    = cpsr_r;
        sticky_s  = sticky_r;
        retired_s = retired_r;
        if (clr_sticky) begin
            sticky_s = 3'b000;
        end else begin
            sticky_s = sticky_r;
        end
        if (accept_s && in_set_flags) begin
            cpsr_s   = in_flags;
            sticky_s = sticky_s | exc_bits(in_flags);
        end else begin
            cpsr_s = cpsr_r;
        end
        if (accept_s) begin
            retired_s = retired_r + 16'd1;
        end else begin
            retired_s = retired_r;
        end
    end

    // State register; reset also drops any accept arriving on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= EMPTY;
            valid_r   <= 1'b0;
            data0_r   <= '0;
            dest0_r   <= '0;
            data1_r   <= '0;
            dest1_r   <= '0;
            cpsr_r    <= 7'd0;
            sticky_r  <= 3'd0;
            retired_r <= 16'd0;
        end else begin
            state_r   <= state_s;
            valid_r   <= valid_s;
            data0_r   <= data0_s;
            dest0_r   <= dest0_s;
            data1_r   <= data1_s;
            dest1_r   <= dest1_s;
            cpsr_r    <= cpsr_s;
            sticky_r  <= sticky_s;
            retired_r <= retired_s;
        end
    end

    assign in_ready = ready_s;
    assign wb_valid = valid_r;
    assign wb_data  = data0_r;
    assign wb_dest  = dest0_r;
    assign cpsr     = cpsr_r;
    assign sticky   = sticky_r;
    assign retired  = retired_r;

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter WIDTH, default 16: result/data width.
REQ-002 SHALL have parameter REGS_LOG2, default 3: destination register index width.
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  ALU result present this cycle.
REQ-006 SHALL have port in_ready  output  1  block can accept a result this cycle.
REQ-007 SHALL have port in_r  input  WIDTH  ALU result r.
REQ-008 SHALL have port in_flags  input  7  {overflow,negative,zero,cout,inf,subnormal,nan}, MSB first.
REQ-009 SHALL have port in_dest  input  REGS_LOG2  destination register index.
REQ-010 SHALL have port in_wr_en  input  1  result is written back; 0 for compare-type ops.
REQ-011 SHALL have port in_set_flags  input  1  result updates CPSR.
REQ-012 SHALL have port wb_valid  output  1  head queue entry is presented to the register file.
REQ-013 SHALL have port wb_ready  input  1  register file takes the entry this cycle.
REQ-014 SHALL have port wb_data  output  WIDTH  head entry result.
REQ-015 SHALL have port wb_dest  output  REGS_LOG2  head entry destination.
REQ-016 SHALL have port cpsr  output  7  current flag register, same bit order as in_flags.
REQ-017 SHALL have port sticky  output  3  accumulated {overflow,inf,nan} exception bits.
REQ-018 SHALL have port clr_sticky  input  1  clears sticky.
REQ-019 SHALL have port retired  output  16  count of accepted results.

Function
REQ-020 SHALL accept a result in a cycle when in_valid && in_ready ("accept").
REQ-021 SHALL hold a 2-entry in-order queue of {in_r, in_dest}; only accepts with in_wr_en=1 enter it.
REQ-022 SHALL drive in_ready = 1 when queue count < 2, or when count = 2 and wb_valid && wb_ready this cycle (pass-through on pop).
REQ-023 SHALL drive wb_valid = (count != 0); wb_data/wb_dest = oldest entry; no combinational path from in_* to wb_* (latency 1 cycle minimum).
REQ-024 SHALL, on simultaneous push and pop, keep count unchanged and preserve order.
REQ-025 SHALL hold wb_data/wb_dest stable while wb_valid && !wb_ready.
REQ-026 SHALL track queue state as EMPTY (0), ONE (1), FULL (2); EMPTY->ONE on push only; ONE->FULL on push only; ONE->EMPTY on pop only; FULL->ONE on pop only; all other combinations hold state.
REQ-027 SHALL accept an in_wr_en=0 result even when the queue is FULL, provided in_valid; such accepts never enter the queue.
REQ-028 SHALL, on accept with in_set_flags=1, load cpsr <= in_flags on the next edge, independent of queue state.
REQ-029 SHALL leave cpsr unchanged on accepts with in_set_flags=0 and on idle cycles.
REQ-030 SHALL, on accept with in_set_flags=1, OR {in_flags[6], in_flags[2], in_flags[0]} into sticky.
REQ-031 SHALL, when clr_sticky=1, clear sticky; a same-cycle flag-setting accept's bits SHALL be ORed into the cleared value (set wins over clear).
REQ-032 SHALL increment retired by 1 on every accept, wrapping 0xFFFF -> 0x0000.
REQ-033 SHALL ignore in_* fields whenever in_valid=0.

Reset
REQ-034 SHALL, on a rising edge with rst_n=0, set queue EMPTY, wb_valid=0, wb_data=0, wb_dest=0, cpsr=0, sticky=0, retired=0.
REQ-035 SHALL drive in_ready=1 in the first cycle after reset release.
REQ-036 SHALL discard queued entries and any same-cycle accept when reset is asserted mid-operation; no wb_valid in the following cycle.

Verification
REQ-037 SHALL verify: push r=0x1234, dest=3, wr_en=1, set_flags=1, flags=7'b0100000 with wb_ready=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_dest=3, cpsr=7'b0100000, retired=1.
REQ-038 SHALL verify: wb_ready=0, push 0x0001 then 0x0002 -> in_ready=0 at count 2; third push wr_en=0 still accepted; release wb_ready -> 0x0001 then 0x0002 in order.
REQ-039 SHALL verify: queue FULL, push wr_en=1 with wb_ready=1 same cycle -> accepted, count stays 2, order preserved.
REQ-040 SHALL verify: flags nan=1 with set_flags=1, then set_flags=0 flags=7'h7F -> sticky=3'b001, cpsr low bit 1 unchanged; clr_sticky with same-cycle inf accept -> sticky=3'b010.
REQ-041 SHALL verify: retired preset by 65535 accepts, one more accept -> retired=0x0000.
REQ-042 SHALL verify: queue holding 2 entries, rst_n=0 for one edge -> wb_valid=0, cpsr=0, sticky=0, retired=0, in_ready=1 next cycle.
